// File: rtl/kernel_runner_pkg.sv
// Shared types and constants for the kernel runner.
package kernel_runner_pkg;

    localparam int unsigned RES_W              = 2;
    localparam int unsigned ADDR_W             = 1;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRELOAD,
        ST_START,
        ST_RUN,
        ST_RB_ADDR,
        ST_RB_DATA,
        ST_RESPOND
    } state_e;

endpackage

// File: rtl/kernel_runner.sv
// Kernel runner: accepts a job, preloads array word 0, starts the kernel,
// waits for completion or timeout, reads word 0 back and returns a result.
module kernel_runner
    import kernel_runner_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CYC_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic              job_init,
    input  logic              job_arr,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_arr,
    output logic [CYC_W-1:0]  res_cycles,
    output logic              res_timeout,
    output logic              k_r_enable,
    output logic              k_init_i,
    output logic              k_ctrl_arr,
    output logic              k_arr_we,
    output logic [ADDR_W-1:0] k_arr_addr,
    output logic              k_arr_wdata,
    input  logic              k_arr_rdata,
    input  logic              k_w_enable,
    input  logic [RES_W-1:0]  k_result
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_accept;
    logic               w_timeout;
    logic               w_run_exit;

    logic               r_job_ready;
    logic               r_res_valid;
    logic [RES_W-1:0]   r_res_data;
    logic               r_res_arr;
    logic [CYC_W-1:0]   r_res_cycles;
    logic               r_res_timeout;
    logic               r_k_r_enable;
    logic               r_k_init_i;
    logic               r_k_ctrl_arr;
    logic               r_k_arr_we;
    logic               r_k_arr_wdata;
    logic [CYC_W-1:0]   r_cnt;

    assign w_timeout  = (r_cnt == CYC_W'(TIMEOUT_CYCLES - 1));
    assign w_run_exit = (r_state == ST_RUN) && (k_w_enable || w_timeout);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (job_valid && r_job_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_PRELOAD;
                end
            end
            ST_PRELOAD: w_state_nxt = ST_START;
            ST_START:   w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (k_w_enable || w_timeout) begin
                    w_state_nxt = ST_RB_ADDR;
                end
            end
            ST_RB_ADDR: w_state_nxt = ST_RB_DATA;
            ST_RB_DATA: w_state_nxt = ST_RESPOND;
            ST_RESPOND: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_job_ready   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_k_r_enable  <= 1'b0;
            r_k_ctrl_arr  <= 1'b0;
            r_k_arr_we    <= 1'b0;
            r_k_arr_wdata <= 1'b0;
            r_k_init_i    <= 1'b0;
        end else begin
            r_job_ready   <= (w_state_nxt == ST_IDLE);
            r_res_valid   <= (w_state_nxt == ST_RESPOND);
            r_k_r_enable  <= (w_state_nxt == ST_START);
            r_k_ctrl_arr  <= (w_state_nxt == ST_PRELOAD) || (w_state_nxt == ST_RB_ADDR) ||
                             (w_state_nxt == ST_RB_DATA);
            r_k_arr_we    <= (w_state_nxt == ST_PRELOAD);
            // PRELOAD is only entered on acceptance, so job_arr is the live job's value
            r_k_arr_wdata <= (w_state_nxt == ST_PRELOAD) ? job_arr : 1'b0;
            if (w_accept) begin
                r_k_init_i <= job_init;
            end
        end
    end

    // RUN cycle counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_res_data    <= '0;
            r_res_arr     <= 1'b0;
            r_res_cycles  <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            if (r_state == ST_START) begin
                r_cnt <= '0;
            end else if ((r_state == ST_RUN) && (r_cnt != {CYC_W{1'b1}})) begin
                r_cnt <= r_cnt + CYC_W'(1);
            end
            // Completion takes priority over a coincident timeout
            if (w_run_exit) begin
                r_res_data    <= k_w_enable ? k_result : '0;
                r_res_timeout <= ~k_w_enable;
                r_res_cycles  <= r_cnt;
            end
            if (r_state == ST_RB_DATA) begin
                r_res_arr <= k_arr_rdata;
            end
        end
    end

    assign job_ready   = r_job_ready;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_arr     = r_res_arr;
    assign res_cycles  = r_res_cycles;
    assign res_timeout = r_res_timeout;
    assign k_r_enable  = r_k_r_enable;
    assign k_init_i    = r_k_init_i;
    assign k_ctrl_arr  = r_k_ctrl_arr;
    assign k_arr_we    = r_k_arr_we;
    assign k_arr_addr  = '0;
    assign k_arr_wdata = r_k_arr_wdata;

endmodule

// File: tb/tb_kernel_runner.sv
// Testbench for kernel_runner with a configurable kernel model and 2-word array.
module tb_kernel_runner;

    localparam int unsigned TO  = 16;
    localparam int unsigned CW  = 8;

    typedef struct packed {
        logic [1:0]    data;
        logic          arr;
        logic [CW-1:0] cyc;
        logic          to;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic          job_init;
    logic          job_arr;
    logic          res_valid;
    logic          res_ready;
    logic [1:0]    res_data;
    logic          res_arr;
    logic [CW-1:0] res_cycles;
    logic          res_timeout;
    logic          k_r_enable;
    logic          k_init_i;
    logic          k_ctrl_arr;
    logic          k_arr_we;
    logic [0:0]    k_arr_addr;
    logic          k_arr_wdata;
    logic          k_arr_rdata;
    logic          k_w_enable;
    logic [1:0]    k_result;

    int n_total = 0;
    int n_bad   = 0;

    kernel_runner #(.TIMEOUT_CYCLES(TO), .CYC_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_init(job_init), .job_arr(job_arr),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_arr(res_arr),
        .res_cycles(res_cycles), .res_timeout(res_timeout),
        .k_r_enable(k_r_enable), .k_init_i(k_init_i),
        .k_ctrl_arr(k_ctrl_arr), .k_arr_we(k_arr_we),
        .k_arr_addr(k_arr_addr), .k_arr_wdata(k_arr_wdata),
        .k_arr_rdata(k_arr_rdata), .k_w_enable(k_w_enable),
        .k_result(k_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Kernel model: done after cfg_lat cycles (0 = never); clears word 0 when init is 0
    int         cfg_lat;
    logic [1:0] cfg_res;
    int         kcnt;
    logic       kstarted;
    logic       kdone;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kstarted <= 1'b0;
            kdone    <= 1'b0;
            kcnt     <= 0;
        end else if (k_r_enable) begin
            kstarted <= 1'b1;
            kdone    <= 1'b0;
            kcnt     <= 0;
        end else if (kstarted && !kdone) begin
            kcnt <= kcnt + 1;
            if (cfg_lat != 0 && kcnt + 1 == cfg_lat) kdone <= 1'b1;
        end
    end

    assign k_w_enable = kdone;
    assign k_result   = kdone ? cfg_res : 2'b00;

    // Array with host/kernel port mux
    logic       kern_we;
    logic       arr_we;
    logic       arr_addr;
    logic       arr_wd;
    logic [1:0] mem;

    assign kern_we  = kstarted && !kdone && (kcnt == 0) && !k_init_i;
    assign arr_we   = k_ctrl_arr ? k_arr_we    : kern_we;
    assign arr_addr = k_ctrl_arr ? k_arr_addr[0] : 1'b0;
    assign arr_wd   = k_ctrl_arr ? k_arr_wdata : 1'b0;

    always @(posedge clk) begin
        if (arr_we) mem[arr_addr] <= arr_wd;
        k_arr_rdata <= mem[arr_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: outcome from kernel latency versus the timeout budget
    function automatic exp_t model(input logic init, input logic arr, input int lat,
                                   input logic [1:0] kres);
        exp_t e;
        if (lat != 0 && lat <= int'(TO) - 1) begin
            e.data = kres;
            e.cyc  = CW'(lat);
            e.to   = 1'b0;
        end else begin
            e.data = 2'b00;
            e.cyc  = CW'(TO - 1);
            e.to   = 1'b1;
        end
        e.arr = init ? arr : 1'b0;
        return e;
    endfunction

    // Offer a job, wait for acceptance, check the PRELOAD-cycle outputs
    task automatic send_job(input logic init, input logic arr, input int lat,
                            input logic [1:0] kres);
        int n;
        cfg_lat   = lat;
        cfg_res   = kres;
        job_init  = init;
        job_arr   = arr;
        job_valid = 1'b1;
        n = 0;
        while (job_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(job_ready), 32'(1));
        @(negedge clk);
        job_valid = 1'b0;
        check("init_i", 32'(k_init_i), 32'(init));
        check("preload", {29'd0, k_ctrl_arr, k_arr_we, k_arr_wdata}, {29'd0, 1'b1, 1'b1, arr});
    endtask

    // Wait for a result, check it and its stability over 'hold' cycles
    task automatic get_result(input exp_t e, input int hold);
        int n;
        logic [12:0] snap;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("res_wait", 32'(res_valid), 32'(1));
        if (res_valid !== 1'b1) return;
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_arr", 32'(res_arr), 32'(e.arr));
        check("res_cycles", 32'(res_cycles), 32'(e.cyc));
        check("res_timeout", 32'(res_timeout), 32'(e.to));
        snap = {res_valid, res_data, res_arr, res_cycles, res_timeout};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold", 32'({res_valid, res_data, res_arr, res_cycles, res_timeout}), 32'(snap));
            check("hold_rdy", 32'(job_ready), 32'(0));
        end
    endtask

    task automatic ack();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("ack_drop", 32'(res_valid), 32'(0));
    endtask

    initial begin
        exp_t        e;
        exp_t        eb;
        logic [CW-1:0] c1;
        logic        seen;
        logic        ri;
        logic        ra;
        int          rl;
        logic [1:0]  rk;
        int          rh;

        rst_n     = 1'b0;
        job_valid = 1'b0;
        job_init  = 1'b0;
        job_arr   = 1'b0;
        res_ready = 1'b0;
        cfg_lat   = 4;
        cfg_res   = 2'b00;

        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(job_ready), 32'(0));
        check("rst_res", {22'd0, res_valid, res_data, res_arr, res_cycles, res_timeout}, 32'd0);
        check("rst_k", {28'd0, k_r_enable, k_ctrl_arr, k_arr_we, k_init_i}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rdy_pre_edge", 32'(job_ready), 32'(0));
        @(negedge clk);
        check("rdy_post_edge", 32'(job_ready), 32'(1));

        // init=0 arr=1: kernel overwrites word 0
        send_job(1'b0, 1'b1, 4, 2'b10);
        e = model(1'b0, 1'b1, 4, 2'b10);
        get_result(e, 0);
        c1 = res_cycles;
        ack();

        // init=1 arr=1: word 0 untouched, same run length
        send_job(1'b1, 1'b1, 4, 2'b11);
        e = model(1'b1, 1'b1, 4, 2'b11);
        get_result(e, 0);
        check("same_cycles", 32'(res_cycles), 32'(c1));
        ack();

        // Kernel never finishes: timeout
        send_job(1'b1, 1'b0, 0, 2'b01);
        get_result(model(1'b1, 1'b0, 0, 2'b01), 0);
        ack();

        // Completion in the timeout cycle wins
        send_job(1'b0, 1'b1, int'(TO) - 1, 2'b01);
        get_result(model(1'b0, 1'b1, int'(TO) - 1, 2'b01), 0);
        ack();

        // Back-pressure with a pending job; accepted the cycle after the handshake
        send_job(1'b1, 1'b0, 3, 2'b11);
        e  = model(1'b1, 1'b0, 3, 2'b11);
        eb = model(1'b0, 1'b1, 3, 2'b11);
        job_init  = 1'b0;
        job_arr   = 1'b1;
        job_valid = 1'b1;
        get_result(e, 10);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_valid_drop", 32'(res_valid), 32'(0));
        check("bp_rdy_after", 32'(job_ready), 32'(1));
        @(negedge clk);
        job_valid = 1'b0;
        check("bp_accepted", 32'(job_ready), 32'(0));
        get_result(eb, 0);
        ack();

        // Reset during RUN: immediate drop, no response
        send_job(1'b1, 1'b1, 12, 2'b10);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst", {29'd0, res_valid, k_ctrl_arr, job_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        check("no_resp", 32'(seen), 32'(0));
        send_job(1'b0, 1'b1, 5, 2'b10);
        get_result(model(1'b0, 1'b1, 5, 2'b10), 1);
        ack();

        // Randomized jobs
        for (int t = 0; t < 12; t++) begin
            ri = 1'($urandom_range(0, 1));
            ra = 1'($urandom_range(0, 1));
            rl = int'($urandom_range(0, 20));
            rk = 2'($urandom_range(0, 3));
            rh = int'($urandom_range(0, 3));
            send_job(ri, ra, rl, rk);
            get_result(model(ri, ra, rl, rk), rh);
            ack();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/kernel_runner.md
KERNEL_RUNNER -- requirements
Module: kernel_runner

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: RUN cycles allowed before abort.
REQ-002 SHALL have parameter CYC_W, default 8: width of the cycle counter.
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 job_valid  in  1  host offers a job.
REQ-006 job_ready  out  1  runner accepts a job.
REQ-007 job_init  in  1  kernel init_i value.
REQ-008 job_arr  in  1  preload value for array word 0.
REQ-009 res_valid  out  1  result available.
REQ-010 res_ready  in  1  host consumes the result.
REQ-011 res_data  out  2  kernel result.
REQ-012 res_arr  out  1  array word 0 read back after the run.
REQ-013 res_cycles  out  CYC_W  RUN-state cycle count.
REQ-014 res_timeout  out  1  run aborted by timeout.
REQ-015 k_r_enable  out  1  kernel start/reset pulse.
REQ-016 k_init_i  out  1  kernel init value.
REQ-017 k_ctrl_arr  out  1  host-side ownership of the kernel array port.
REQ-018 k_arr_we  out  1  array write enable.
REQ-019 k_arr_addr  out  1  array address.
REQ-020 k_arr_wdata  out  1  array write data.
REQ-021 k_arr_rdata  in  1  array read data, valid one cycle after a read address.
REQ-022 k_w_enable  in  1  kernel done, held high.
REQ-023 k_result  in  2  kernel result, valid while k_w_enable is high.

Function
REQ-024 FSM states SHALL be IDLE, PRELOAD, START, RUN, RB_ADDR, RB_DATA, RESPOND.
REQ-025 IDLE: job_ready=1. On job_valid&job_ready, latch job_init/job_arr, go to PRELOAD.
REQ-026 job_ready SHALL be 0 in every state other than IDLE. A job offered in the same cycle as a res handshake SHALL NOT be accepted.
REQ-027 PRELOAD (1 cycle): k_ctrl_arr=1, k_arr_we=1, k_arr_addr=0, k_arr_wdata=latched job_arr; then go to START.
REQ-028 START (1 cycle): k_r_enable=1, k_ctrl_arr=0, cycle counter cleared to 0; then go to RUN.
REQ-029 k_init_i SHALL drive the latched job_init continuously from acceptance until the next acceptance.
REQ-030 RUN: k_ctrl_arr=0 (kernel owns the array); counter increments each cycle, saturating at 2^CYC_W-1.
REQ-031 RUN with k_w_enable=1: capture k_result into res_data, res_timeout=0, go to RB_ADDR.
REQ-032 RUN with k_w_enable=0 and counter==TIMEOUT_CYCLES-1: res_data=0, res_timeout=1, go to RB_ADDR.
REQ-033 If k_w_enable and the timeout condition occur in the same cycle, completion SHALL win.
REQ-034 RB_ADDR: k_ctrl_arr=1, k_arr_we=0, k_arr_addr=0. RB_DATA: k_ctrl_arr=1; capture k_arr_rdata into res_arr; go to RESPOND.
REQ-035 RESPOND: res_valid=1; res_data, res_arr, res_cycles, res_timeout held stable; on res_ready go to IDLE.
REQ-036 In every other state, res_valid=0.
REQ-037 res_cycles SHALL be the number of RUN cycles before exit.
REQ-038 Outside PRELOAD, k_arr_we=0; outside PRELOAD and RB_*, k_ctrl_arr=0.
REQ-039 k_arr_addr and k_arr_wdata SHALL be 0 whenever they are not in use; outputs are never X.

Reset
REQ-040 rst_n low SHALL force IDLE immediately, asynchronously, including mid-RUN or mid-RESPOND; any job in flight is dropped with no response.
REQ-041 Reset values: job_ready=0 while rst_n is low; res_valid=0, res_data=0, res_arr=0, res_cycles=0, res_timeout=0.
REQ-042 Reset values: k_r_enable=0, k_ctrl_arr=0, k_arr_we=0, k_init_i=0.
REQ-043 The first job SHALL be accepted no earlier than the first clk edge after rst_n deasserts.

Structure
REQ-044 Shared package kernel_runner_pkg SHALL hold the state enum, the result width constant (2), the address width constant (1), and the default TIMEOUT_CYCLES.
REQ-045 The block SHALL be a single module with no sub-modules; the cycle counter is inline.

Verification (bench instantiates the real kernel and its array)
REQ-046 Job init=0, arr=1 -> res_data=2, res_arr=0 (kernel overwrote word 0), res_timeout=0.
REQ-047 Job init=1, arr=1 -> res_data=3, res_arr=1 (word 0 untouched), res_timeout=0; res_cycles equals the REQ-046 value.
REQ-048 Kernel stub holding k_w_enable=0, TIMEOUT_CYCLES=16 -> res_timeout=1, res_data=0, res_cycles=15.
REQ-049 res_ready held low for 10 cycles with job_valid high -> all res_* stable, job_ready=0 throughout; job accepted the cycle after the handshake.
REQ-050 rst_n pulsed low during RUN -> res_valid=0 and k_ctrl_arr=0 immediately, no response; next job completes normally.
REQ-051 Stub asserts k_w_enable in the timeout cycle (TIMEOUT_CYCLES=16) -> res_timeout=0, res_data=k_result.
